// File: rtl/spi_ram_pkg.sv
// Shared opcode constants and FSM state type for the SPI RAM burst block.
// No logic, no latency.
// No flow control.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR  = 2'b00;
    localparam logic [1:0] OP_WR_DATA  = 2'b01;
    localparam logic [1:0] OP_RD_ADDR  = 2'b10;
    localparam logic [1:0] OP_RD_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

endpackage

// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave shift logic and the RAM block.
// Wires only, no latency.
// Response side uses tx_valid/tx_ready; command side has no backpressure (busy/cmd_drop).
interface spi_ram_burst_if #(
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W+1:0] din;
    logic              tx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              busy;
    logic              cmd_drop;
    logic              addr_err;

    modport master (
        output rx_valid, din, tx_ready,
        input  dout, tx_valid, busy, cmd_drop, addr_err
    );

    modport slave (
        input  rx_valid, din, tx_ready,
        output dout, tx_valid, busy, cmd_drop, addr_err
    );
endinterface

// File: rtl/spi_ram_sp_array.sv
// Single-port RAM, synchronous write, registered read; out-of-range writes dropped, reads give 0.
// Read data valid one cycle after re.
// No backpressure; caller sequences we/re.
module spi_ram_sp_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              addr_ok;

    assign addr_ok = ({1'b0, addr} < DEPTH_C);

    always_ff @(posedge clk) begin
        if (we && addr_ok) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = addr_ok ? mem[addr] : '0;
        end
    end

    // Output register is reset so dout reads 0 out of reset; contents are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// SPI command decoder driving a single-port RAM with auto-increment writes and counted burst reads.
// First read word valid 2 edges after the burst command; one word per 2 cycles thereafter.
// Words held until tx_ready; commands arriving while busy are discarded and flagged on cmd_drop.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_burst_if.slave bus
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(MEM_DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_C);
    endfunction

    // Wraps at the end of the array; out-of-range addresses just roll modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_C) ? '0 : a + 1'b1;
    endfunction

    state_e            state_d, state_q;
    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
    logic [7:0]        rem_d, rem_q;
    logic              tx_valid_d, tx_valid_q;
    logic              busy_d, busy_q;
    logic              cmd_drop_d, cmd_drop_q;
    logic              addr_err_d, addr_err_q;

    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;

    assign opcode  = bus.din[DATA_W+1:DATA_W];
    assign payload = bus.din[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rem_d      = rem_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        cmd_drop_d = 1'b0;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    case (opcode)
                        OP_WR_ADDR: wr_addr_d = payload[ADDR_W-1:0];
                        OP_WR_DATA: begin
                            mem_we     = in_range(wr_addr_q);
                            addr_err_d = !in_range(wr_addr_q);
                            if (AUTO_INC) begin
                                wr_addr_d = next_addr(wr_addr_q);
                            end
                        end
                        OP_RD_ADDR: rd_addr_d = payload[ADDR_W-1:0];
                        default: begin
                            rem_d   = payload[7:0];
                            busy_d  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_FETCH: begin
                mem_re     = 1'b1;
                mem_addr   = rd_addr_q;
                addr_err_d = !in_range(rd_addr_q);
                tx_valid_d = 1'b1;
                state_d    = ST_PRESENT;
            end
            default: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (rem_q == 8'd0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d     = rem_q - 8'd1;
                        rd_addr_d = next_addr(rd_addr_q);
                        state_d   = ST_FETCH;
                    end
                end
            end
        endcase

        // busy_q covers both burst states, so any command there is lost.
        if (busy_q && bus.rx_valid) begin
            cmd_drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rem_q      <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            cmd_drop_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rem_q      <= rem_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            cmd_drop_q <= cmd_drop_d;
            addr_err_q <= addr_err_d;
        end
    end

    spi_ram_sp_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (payload),
        .rdata (bus.dout)
    );

    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.cmd_drop = cmd_drop_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst with a 200-word array and write auto-increment.
module tb_spi_ram_burst;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    spi_ram_burst_if #(.DATA_W(8)) bus ();

    spi_ram_burst #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .MEM_DEPTH (200),
        .AUTO_INC  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] pl);
        bus.rx_valid = 1'b1;
        bus.din      = {op, pl};
        tick();
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_w [3];
        checks = 0;
        errors = 0;
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.din      = '0;
        bus.tx_ready = 1'b0;
        exp_w[0] = 8'hA1;
        exp_w[1] = 8'hA2;
        exp_w[2] = 8'hA3;

        tick();
        tick();
        chk("rst_dout", bus.dout, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmd_drop", bus.cmd_drop, 0);
        chk("rst_addr_err", bus.addr_err, 0);
        rst_n = 1'b1;
        tick();

        // Basic burst of 3 from 0x10
        send(2'b00, 8'h10);
        send(2'b01, 8'hA1);
        chk("wr_addr_err", bus.addr_err, 0);
        send(2'b01, 8'hA2);
        send(2'b01, 8'hA3);
        send(2'b10, 8'h10);
        bus.tx_ready = 1'b1;
        send(2'b11, 8'd2);
        chk("b3_busy_rise", bus.busy, 1);
        chk("b3_tv_lat", bus.tx_valid, 0);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("b3_tv_hi", bus.tx_valid, 1);
            chk("b3_dout", bus.dout, exp_w[w]);
            chk("b3_busy_mid", bus.busy, 1);
            tick();
            chk("b3_tv_lo", bus.tx_valid, 0);
            chk("b3_busy_after", bus.busy, (w < 2) ? 1 : 0);
        end
        bus.tx_ready = 1'b0;

        // Address wrap at MEM_DEPTH-1
        send(2'b00, 8'd199);
        send(2'b01, 8'h55);
        chk("wrap_wr1_err", bus.addr_err, 0);
        send(2'b01, 8'h66);
        chk("wrap_wr2_err", bus.addr_err, 0);
        send(2'b10, 8'd199);
        bus.tx_ready = 1'b1;
        send(2'b11, 8'd1);
        tick();
        chk("wrap_dout0", bus.dout, 8'h55);
        chk("wrap_err0", bus.addr_err, 0);
        tick();
        tick();
        chk("wrap_dout1", bus.dout, 8'h66);
        chk("wrap_tv1", bus.tx_valid, 1);
        chk("wrap_err1", bus.addr_err, 0);
        tick();
        chk("wrap_done", bus.busy, 0);
        bus.tx_ready = 1'b0;

        // Backpressure on a single-word read
        send(2'b10, 8'h11);
        send(2'b11, 8'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_tv", bus.tx_valid, 1);
            chk("bp_dout", bus.dout, 8'hA2);
            tick();
        end
        chk("bp_busy_hold", bus.busy, 1);
        bus.tx_ready = 1'b1;
        tick();
        chk("bp_tv_done", bus.tx_valid, 0);
        chk("bp_busy_done", bus.busy, 0);
        bus.tx_ready = 1'b0;

        // Command dropped during a burst
        send(2'b00, 8'h11);
        send(2'b10, 8'h10);
        send(2'b11, 8'd1);
        tick();
        chk("drop_dout0", bus.dout, 8'hA1);
        send(2'b01, 8'hEE);
        chk("drop_pulse", bus.cmd_drop, 1);
        tick();
        chk("drop_pulse_end", bus.cmd_drop, 0);
        chk("drop_tv_hold", bus.tx_valid, 1);
        chk("drop_dout_hold", bus.dout, 8'hA1);
        bus.tx_ready = 1'b1;
        tick();
        tick();
        chk("drop_dout1", bus.dout, 8'hA2);
        tick();
        chk("drop_done", bus.busy, 0);
        bus.tx_ready = 1'b0;

        // Out-of-range write and read
        send(2'b00, 8'd210);
        send(2'b01, 8'h77);
        chk("oor_wr_err", bus.addr_err, 1);
        tick();
        chk("oor_wr_err_end", bus.addr_err, 0);
        send(2'b01, 8'h78);
        chk("oor_wr2_err", bus.addr_err, 1);
        send(2'b10, 8'd210);
        bus.tx_ready = 1'b1;
        send(2'b11, 8'd0);
        chk("oor_rd_err_pre", bus.addr_err, 0);
        tick();
        chk("oor_rd_dout", bus.dout, 0);
        chk("oor_rd_err", bus.addr_err, 1);
        tick();
        chk("oor_rd_err_end", bus.addr_err, 0);
        chk("oor_rd_done", bus.busy, 0);

        // Reset during PRESENT of word 2 of 4
        send(2'b10, 8'h10);
        send(2'b11, 8'd3);
        tick();
        tick();
        bus.tx_ready = 1'b0;
        tick();
        chk("mid_dout_w2", bus.dout, 8'hA2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tv", bus.tx_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_post_tv", bus.tx_valid, 0);
        send(2'b10, 8'h12);
        bus.tx_ready = 1'b1;
        send(2'b11, 8'd0);
        tick();
        chk("mid_new_tv", bus.tx_valid, 1);
        chk("mid_new_dout", bus.dout, 8'hA3);
        tick();
        chk("mid_new_done", bus.busy, 0);
        bus.tx_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
